pmem_arbiter: RTL and testbench

// - Sits directly downstream of inst_cache and data_cache. Multiplexes their line-fill/writeback

---
 rtl/pmem_arbiter_pkg.sv | 12 +
 rtl/pmem_arbiter_holdoff.sv | 30 +++
 rtl/pmem_arbiter.sv | 124 ++++++++++++
 tb/tb_pmem_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: state/port enums, line width
// and the RV32I word type used for line addresses.
package pmem_arbiter_pkg;

  typedef logic [31:0] rv32i_word;

  localparam int S_LINE = 256;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D} arb_state_t;
  typedef enum logic {PORT_I, PORT_D} arb_port_t;

endpackage

// File: rtl/pmem_arbiter_holdoff.sv
// Per-port post-completion holdoff: loads HOLDOFF when the port's transaction
// completes, then counts down to zero; the port may only be granted at zero.
module pmem_arbiter_holdoff #(
  parameter int HOLDOFF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic ready
);

  localparam int CW = $clog2(HOLDOFF + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(HOLDOFF);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign ready = (count == '0);

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter multiplexing I-cache fills and D-cache fills/writebacks
// onto one physical-memory port, one 256-bit line per transaction.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int HOLDOFF = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  rv32i_word         i_address,
  input  logic              i_read,
  output logic [S_LINE-1:0] i_rdata,
  output logic              i_resp,
  input  rv32i_word         d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [S_LINE-1:0] d_wdata,
  output logic [S_LINE-1:0] d_rdata,
  output logic              d_resp,
  output rv32i_word         mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [S_LINE-1:0] mem_wdata,
  input  logic [S_LINE-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t state;
  arb_port_t  last_grant;

  logic i_ready, d_ready;
  logic i_elig, d_elig;
  logic grant_i, grant_d;
  logic busy_i, busy_d;

  assign busy_i = (state == ARB_BUSY_I);
  assign busy_d = (state == ARB_BUSY_D);

  pmem_arbiter_holdoff #(.HOLDOFF(HOLDOFF)) u_holdoff_i (
    .clk   (clk),
    .rst   (rst),
    .load  (busy_i && mem_resp),
    .ready (i_ready)
  );

  pmem_arbiter_holdoff #(.HOLDOFF(HOLDOFF)) u_holdoff_d (
    .clk   (clk),
    .rst   (rst),
    .load  (busy_d && mem_resp),
    .ready (d_ready)
  );

  // Grant only from IDLE; on a tie the port that was not served last wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    i_elig  = 1'b0;
    d_elig  = 1'b0;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == ARB_IDLE) begin
      i_elig  = i_read && i_ready;
      d_elig  = (d_read || d_write) && d_ready;
      grant_d = d_elig && (!i_elig || last_grant == PORT_I);
      grant_i = i_elig && !grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      last_grant <= PORT_I;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            state      <= ARB_BUSY_D;
            last_grant <= PORT_D;
          end else if (grant_i) begin
            state      <= ARB_BUSY_I;
            last_grant <= PORT_I;
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (mem_resp) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Memory-side request is latched at grant and held until mem_resp; a
  // simultaneous d_read/d_write is served as a writeback.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_address <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wdata   <= '0;
    end else if (grant_d) begin
      mem_address <= d_address;
      mem_read    <= d_read && !d_write;
      mem_write   <= d_write;
      mem_wdata   <= d_wdata;
    end else if (grant_i) begin
      mem_address <= i_address;
      mem_read    <= 1'b1;
      mem_write   <= 1'b0;
    end else if ((busy_i || busy_d) && mem_resp) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end
  end

  assign i_resp  = busy_i && mem_resp;
  assign d_resp  = busy_d && mem_resp;
  assign i_rdata = busy_i ? mem_rdata : '0;
  assign d_rdata = busy_d ? mem_rdata : '0;

  d_read_write_exclusive : assert property (
    @(posedge clk) disable iff (!rst) !(d_read && d_write)
  );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: reset, round-robin contention, holdoff,
// lone fill, writeback hold, stray response, request drop and mid-BUSY reset.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_address, d_address, mem_address;
  logic         i_read, i_resp;
  logic         d_read, d_write, d_resp;
  logic [255:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic         mem_read, mem_write, mem_resp;

  int errors = 0;
  int checks = 0;

  pmem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_address   (i_address),
    .i_read      (i_read),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_address   (d_address),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (obs=timeout exp=finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [255:0] D1    = {8{32'hD1D1_0001}};
  localparam logic [255:0] I1    = {8{32'h1111_0002}};
  localparam logic [255:0] PAT_A = {32{8'hA5}};
  localparam logic [255:0] PAT_W = {16{16'h1234}};

  initial begin
    rst = 1'b0; i_read = 1'b1; d_read = 1'b1; d_write = 1'b0;
    i_address = 32'h0000_1000; d_address = 32'h0000_2000;
    d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;

    // Reset held with both requests up
    step(); step(); step();
    check("rst_mem_read",  mem_read,  0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr",  mem_address, 0);
    check("rst_i_resp",    i_resp, 0);
    check("rst_d_resp",    d_resp, 0);

    // Contention after release: D first, since last_grant resets to I
    rst = 1'b1;
    step();
    check("cont_d_read",  mem_read, 1);
    check("cont_d_write", mem_write, 0);
    check("cont_d_addr",  mem_address, 32'h0000_2000);
    mem_rdata = D1; mem_resp = 1'b1; #1;
    check("cont_d_resp",  d_resp, 1);
    check("cont_d_rdata", d_rdata, D1);
    check("cont_d_no_i",  i_resp, 0);
    step();
    mem_resp = 1'b0; d_read = 1'b0; #1;
    check("cont_idle_read", mem_read, 0);
    check("cont_idle_resp", d_resp, 0);
    step();
    check("cont_i_read", mem_read, 1);
    check("cont_i_addr", mem_address, 32'h0000_1000);
    step(); step();
    check("cont_i_hold", mem_read, 1);
    mem_rdata = I1; mem_resp = 1'b1; #1;
    check("cont_i_resp",  i_resp, 1);
    check("cont_i_rdata", i_rdata, I1);
    check("cont_i_no_d",  d_resp, 0);

    // Holdoff: i_read lingers, no grant for two IDLE cycles
    step();
    mem_resp = 1'b0; #1;
    check("hold_c1", mem_read, 0);
    check("hold_resp_pulse", i_resp, 0);
    step();
    check("hold_c2", mem_read, 0);
    step();
    check("hold_c3", mem_read, 0);
    step();
    check("hold_regrant", mem_read, 1);

    // Lone I fill answered after 5 cycles
    step(); step(); step(); step(); step();
    check("fill_hold_read", mem_read, 1);
    check("fill_hold_addr", mem_address, 32'h0000_1000);
    check("fill_no_resp",   i_resp, 0);
    mem_rdata = PAT_A; mem_resp = 1'b1; #1;
    check("fill_i_resp",  i_resp, 1);
    check("fill_i_rdata", i_rdata, PAT_A);
    step();
    mem_resp = 1'b0; i_read = 1'b0; #1;
    check("fill_done", mem_read, 0);

    // D writeback, requester inputs change while BUSY
    d_write = 1'b1; d_address = 32'h8000_0040; d_wdata = PAT_W;
    step();
    check("wb_write", mem_write, 1);
    check("wb_read",  mem_read, 0);
    check("wb_addr",  mem_address, 32'h8000_0040);
    check("wb_data",  mem_wdata, PAT_W);
    d_address = 32'hDEAD_0000; d_wdata = '1;
    step(); step(); step();
    check("wb_hold_write", mem_write, 1);
    check("wb_hold_addr",  mem_address, 32'h8000_0040);
    check("wb_hold_data",  mem_wdata, PAT_W);
    check("wb_hold_read",  mem_read, 0);
    mem_resp = 1'b1; #1;
    check("wb_d_resp", d_resp, 1);
    step();
    mem_resp = 1'b0; d_write = 1'b0; #1;
    check("wb_done_write", mem_write, 0);
    check("wb_done_resp",  d_resp, 0);

    // Stray mem_resp in IDLE
    step(); step(); step();
    mem_resp = 1'b1; #1;
    check("stray_i_resp", i_resp, 0);
    check("stray_d_resp", d_resp, 0);
    step();
    mem_resp = 1'b0; #1;
    check("stray_no_read",  mem_read, 0);
    check("stray_no_write", mem_write, 0);

    // Request dropped mid-BUSY still completes
    i_read = 1'b1; i_address = 32'h0000_3000;
    step();
    check("drop_grant", mem_read, 1);
    check("drop_addr",  mem_address, 32'h0000_3000);
    i_read = 1'b0;
    step(); step();
    check("drop_hold", mem_read, 1);
    mem_rdata = I1; mem_resp = 1'b1; #1;
    check("drop_i_resp",  i_resp, 1);
    check("drop_i_rdata", i_rdata, I1);
    step();
    mem_resp = 1'b0; #1;

    // Reset in the middle of a writeback
    step(); step(); step();
    d_write = 1'b1; d_address = 32'h0000_0040; d_wdata = PAT_W;
    step();
    check("rstmid_write", mem_write, 1);
    d_write = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1; #1;
    check("rstmid_write_low", mem_write, 0);
    check("rstmid_no_resp",   d_resp, 0);
    mem_resp = 1'b1; #1;
    check("rstmid_stray_d", d_resp, 0);
    check("rstmid_stray_i", i_resp, 0);
    step();
    mem_resp = 1'b0; #1;
    check("rstmid_idle_write", mem_write, 0);
    check("rstmid_idle_read",  mem_read, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
